// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: valid/ready bus access, byte-lane steering, load extension.
// Optional response timeout enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic            reg_write_in,
    input  logic [2:0]      funct3_in,
    input  logic [4:0]      rd_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [XLEN-1:0] store_data_in,
    output logic            stall_out,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_wstrb,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            wb_valid,
    output logic            wb_reg_write,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign_out,
    output logic            bus_err_out
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e          state_q;
    logic            we_q;
    logic            reg_write_q;
    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [1:0]      off_q;

    logic            is_mem;
    logic            misaligned;
    logic            accept;
    logic            timeout;
    logic [XLEN-1:0] st_wdata;
    logic [3:0]      st_wstrb;

    function automatic logic [XLEN-1:0] load_extract(input logic [2:0]      f3,
                                                     input logic [1:0]      off,
                                                     input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] sh;
        sh = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  load_extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  load_extract = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  load_extract = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: load_extract = sh;
        endcase
    endfunction

    always_comb begin
        is_mem     = mem_read_in | mem_write_in;
        // funct3[1] selects word size, funct3[0] halfword
        misaligned = funct3_in[1] ? (addr_in[1:0] != 2'b00) : (funct3_in[0] & addr_in[0]);
        accept     = valid_in & is_mem & ~misaligned;
        case (funct3_in[1:0])
            2'b00: begin
                st_wdata = {(XLEN/8){store_data_in[7:0]}};
                st_wstrb = 4'b0001 << addr_in[1:0];
            end
            2'b01: begin
                st_wdata = {(XLEN/16){store_data_in[15:0]}};
                st_wstrb = 4'b0011 << addr_in[1:0];
            end
            default: begin
                st_wdata = store_data_in;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    assign stall_out = ~reset & ((state_q == StIdle && accept) ||
                                 (state_q == StReq && !timeout) ||
                                 (state_q == StResp && !bus_rvalid && !timeout));

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CntW-1:0] wait_cnt_q;
    logic            waiting;
    logic            bus_err_q;

    assign waiting = (state_q == StReq && !bus_gnt) || (state_q == StResp && !bus_rvalid);
    assign timeout = waiting && (wait_cnt_q == CntW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (state_q == StIdle || (state_q == StReq && bus_gnt)) begin
                wait_cnt_q <= '0;
            end else if (waiting) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    assign bus_err_out = bus_err_q;
`else
    assign timeout     = 1'b0;
    assign bus_err_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            reg_write_q  <= 1'b0;
            funct3_q     <= '0;
            rd_q         <= '0;
            off_q        <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            bus_wstrb    <= '0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_out <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            misalign_out <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (valid_in) begin
                        if (!is_mem || misaligned) begin
                            wb_valid     <= 1'b1;
                            wb_reg_write <= ~is_mem & reg_write_in;
                            wb_rd        <= rd_in;
                            wb_data      <= addr_in;
                            misalign_out <= is_mem;
                        end else begin
                            we_q        <= mem_write_in;
                            reg_write_q <= reg_write_in;
                            funct3_q    <= funct3_in;
                            rd_q        <= rd_in;
                            off_q       <= addr_in[1:0];
                            bus_req     <= 1'b1;
                            bus_we      <= mem_write_in;
                            bus_addr    <= {addr_in[XLEN-1:2], 2'b00};
                            bus_wdata   <= st_wdata;
                            bus_wstrb   <= st_wstrb;
                            state_q     <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (timeout) begin
                        bus_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        state_q  <= StIdle;
                    end else if (bus_gnt) begin
                        bus_req <= 1'b0;
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (bus_rvalid) begin
                        wb_valid     <= 1'b1;
                        wb_reg_write <= reg_write_q & ~we_q;
                        wb_rd        <= rd_q;
                        wb_data      <= load_extract(funct3_q, off_q, bus_rdata);
                        state_q      <= StIdle;
                    end else if (timeout) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized ops vs. a byte-level model.
// The timeout section is compiled only when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, mem_read_in, mem_write_in, reg_write_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic [31:0] addr_in, store_data_in;
    logic        stall_out, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_out, bus_err_out;

    int total = 0;
    int bad   = 0;

    mem_access_unit #(.XLEN(32), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .reg_write_in(reg_write_in), .funct3_in(funct3_in),
        .rd_in(rd_in), .addr_in(addr_in), .store_data_in(store_data_in),
        .stall_out(stall_out), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .wb_valid(wb_valid),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_out(misalign_out), .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        return f3[1] ? 4 : (f3[0] ? 2 : 1);
    endfunction

    // Byte-level reference: pick nb bytes starting at byte offset, then sign/zero extend.
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int          nb;
        logic [63:0] v;
        logic [63:0] lim;
        nb  = size_bytes(f3);
        v   = {32'b0, rdata} >> (8 * (addr % 4));
        lim = 64'd1 << (8 * nb);
        if (nb < 4) begin
            v = v % lim;
            if (!f3[2] && v >= (lim / 2)) v = v - lim;
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input int nb, input logic [31:0] d);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % nb) +: 8];
        return w;
    endfunction

    function automatic logic [3:0] exp_wstrb(input int nb, input logic [31:0] addr);
        int m;
        m = ((1 << nb) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    task automatic drive_idle();
        valid_in = 0; mem_read_in = 0; mem_write_in = 0; reg_write_in = 0;
        funct3_in = 0; rd_in = 0; addr_in = 0; store_data_in = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    endtask

    // One instruction: gdly idle REQ cycles before the gnt cycle, rdly idle RESP cycles before rvalid.
    task automatic run_op(input bit rd_op, input bit wr_op, input bit rw, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int gdly, input int rdly,
                          output logic [31:0] got);
        bit is_mem, mis;
        int nb, stalls;
        is_mem = rd_op || wr_op;
        nb     = size_bytes(f3);
        mis    = is_mem && ((addr % nb) != 0);
        @(negedge clk);
        valid_in = 1; mem_read_in = rd_op; mem_write_in = wr_op; reg_write_in = rw;
        funct3_in = f3; rd_in = rd; addr_in = addr; store_data_in = sdata;
        bus_gnt = 0; bus_rvalid = 0;
        #1;
        check("accept_stall", stall_out, is_mem && !mis);
        check("accept_req", bus_req, 0);
        if (!is_mem || mis) begin
            @(negedge clk);
            drive_idle();
            #1;
            check("pt_wb_valid", wb_valid, 1);
            check("pt_wb_reg_write", wb_reg_write, mis ? 0 : rw);
            check("pt_wb_rd", wb_rd, rd);
            check("pt_misalign", misalign_out, mis);
            check("pt_bus_req", bus_req, 0);
            check("pt_stall", stall_out, 0);
            if (!is_mem) check("pt_wb_data", wb_data, addr);
            got = wb_data;
            return;
        end
        stalls = 1;
        for (int k = 0; k <= gdly; k++) begin
            @(negedge clk);
            bus_gnt = (k == gdly);
            #1;
            check("req_bus_req", bus_req, 1);
            check("req_bus_we", bus_we, wr_op);
            check("req_bus_addr", bus_addr, addr - (addr % 4));
            if (wr_op) begin
                check("req_wdata", bus_wdata, exp_wdata(nb, sdata));
                check("req_wstrb", bus_wstrb, exp_wstrb(nb, addr));
            end
            check("req_wb_valid", wb_valid, 0);
            if (stall_out === 1'b1) stalls++;
        end
        for (int j = 0; j <= rdly; j++) begin
            @(negedge clk);
            bus_gnt = 0;
            bus_rvalid = (j == rdly);
            bus_rdata = (j == rdly) ? rdata : $urandom;
            #1;
            check("resp_bus_req", bus_req, 0);
            check("resp_stall", stall_out, j != rdly);
            check("resp_wb_valid", wb_valid, 0);
            if (stall_out === 1'b1) stalls++;
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("done_wb_valid", wb_valid, 1);
        check("done_wb_reg_write", wb_reg_write, rw && !wr_op);
        check("done_wb_rd", wb_rd, rd);
        check("done_stall", stall_out, 0);
        check("done_misalign", misalign_out, 0);
        if (rd_op) check("done_wb_data", wb_data, exp_load(f3, addr, rdata));
        check("stall_len", stalls, 2 + gdly + rdly);
        got = wb_data;
    endtask

    logic [31:0] got;
    logic [2:0]  lf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        drive_idle();
        reset = 1;
        #12;
        check("rst_stall", stall_out, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_misalign", misalign_out, 0);
        check("rst_bus_err", bus_err_out, 0);
        @(negedge clk);
        reset = 0;

        run_op(0, 0, 1, 3'b000, 5'd5, 32'h1234, 0, 0, 0, 0, got);
        check("add_data", got, 32'h1234);
        run_op(1, 0, 1, 3'b000, 5'd6, 32'h1003, 0, 32'h80AABBCC, 1, 0, got);
        check("lb_data", got, 32'hFFFFFF80);
        run_op(1, 0, 1, 3'b101, 5'd7, 32'h2002, 0, 32'h9ABC0000, 0, 0, got);
        check("lhu_data", got, 32'h00009ABC);
        run_op(1, 0, 1, 3'b001, 5'd8, 32'h2002, 0, 32'h9ABC0000, 0, 2, got);
        check("lh_data", got, 32'hFFFF9ABC);
        run_op(0, 1, 1, 3'b000, 5'd9, 32'h3001, 32'hDEADBEEF, 0, 4, 1, got);
        run_op(1, 0, 1, 3'b010, 5'd10, 32'h4002, 0, 0, 0, 0, got);

        // Reset while waiting in RESP for an aligned LW
        @(negedge clk);
        valid_in = 1; mem_read_in = 1; reg_write_in = 1; funct3_in = 3'b010;
        rd_in = 5'd11; addr_in = 32'h5000;
        @(negedge clk);
        bus_gnt = 1;
        #1;
        check("rstmid_req", bus_req, 1);
        @(negedge clk);
        bus_gnt = 0;
        #1;
        check("rstmid_stall_before", stall_out, 1);
        reset = 1;
        #1;
        check("rstmid_stall", stall_out, 0);
        check("rstmid_bus_req", bus_req, 0);
        check("rstmid_bus_addr", bus_addr, 0);
        check("rstmid_wb_valid", wb_valid, 0);
        check("rstmid_wb_rd", wb_rd, 0);
        @(negedge clk);
        reset = 0;
        drive_idle();
        run_op(0, 0, 1, 3'b000, 5'd12, 32'hCAFE0000, 0, 0, 0, 0, got);

`ifdef MEM_TIMEOUT_EN
        @(negedge clk);
        valid_in = 1; mem_read_in = 1; reg_write_in = 1; funct3_in = 3'b010;
        rd_in = 5'd13; addr_in = 32'h6000;
        @(negedge clk);
        bus_gnt = 1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            bus_gnt = 0;
            #1;
            check("to_stall", stall_out, j != 7);
            check("to_err_early", bus_err_out, 0);
        end
        @(negedge clk);
        drive_idle();
        #1;
        check("to_bus_err", bus_err_out, 1);
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_reg_write", wb_reg_write, 0);
        run_op(0, 0, 1, 3'b000, 5'd14, 32'h77, 0, 0, 0, 0, got);
`endif

        for (int n = 0; n < 60; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            f3 = (kind == 1) ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a - (a % size_bytes(f3));
            run_op(kind == 1, kind == 2, 1'($urandom), f3, 5'($urandom), a, $urandom,
                   $urandom, $urandom_range(0, 3), $urandom_range(0, 3), got);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns registered load/store controls into a valid/ready data-bus transaction, with byte-lane steering and load extension.
- Registers the result toward MEM/WB and holds the upstream pipeline with a stall while a bus access is outstanding.
- Non-memory instructions pass straight through with one-cycle latency.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT_CYC, 255, response-wait limit in cycles (used only with MEM_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- valid_in  in  1  EX/MEM slot holds a live instruction
- mem_read_in  in  1  load
- mem_write_in  in  1  store
- reg_write_in  in  1  instruction writes rd
- funct3_in  in  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (stores use 000/001/010)
- rd_in  in  5  destination register
- addr_in  in  XLEN  ALU result: effective address, or writeback value for non-memory ops
- store_data_in  in  XLEN  rs2 value
- stall_out  out  1  hold EX/MEM and earlier stages
- bus_req  out  1  request valid
- bus_we  out  1  write
- bus_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- bus_wdata  out  XLEN  lane-replicated store data
- bus_wstrb  out  4  byte enables
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  response valid (loads and stores)
- bus_rdata  in  XLEN  read data
- wb_valid  out  1  MEM/WB slot valid
- wb_reg_write  out  1  write enable to WB
- wb_rd  out  5  destination
- wb_data  out  XLEN  load result or pass-through value
- misalign_out  out  1  one-cycle pulse on a misaligned access
- bus_err_out  out  1  one-cycle pulse on timeout (MEM_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Latched instruction fields are cleared.
- States: IDLE, REQ, RESP.
- IDLE:
  - valid_in with neither mem_read_in nor mem_write_in: next cycle wb_valid=1, wb_data=addr_in, wb_rd=rd_in, wb_reg_write=reg_write_in. stall_out stays 0.
  - valid_in with a memory op: latch all inputs, assert stall_out combinationally the same cycle, go to REQ.
- REQ:
  - bus_req=1 with addr/we/wdata/wstrb held stable until bus_gnt is sampled high, then go to RESP.
  - bus_req drops the cycle after the grant.
- RESP:
  - Wait for bus_rvalid.
  - Then register wb_valid=1, wb_reg_write=latched reg_write (forced 0 for stores), wb_data=extended load data.
  - stall_out deasserts in the same cycle rvalid is seen; return to IDLE.
- Minimum memory-op latency is 3 cycles (accept, grant, response) when gnt and rvalid arrive immediately.
- wb_valid pulses for one cycle per instruction; it is 0 in any cycle with no completion.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, wstrb=0001<<a[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=0011<<a[1:0].
  - SW: wdata=d, wstrb=1111.
- Load extract:
  - Shift rdata right by 8*a[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes unchanged.
- Misaligned access (halfword with a[0]=1, word with a[1:0]!=0):
  - No bus transaction.
  - misalign_out pulses one cycle after acceptance, together with wb_valid=1 and wb_reg_write=0.
  - Remain in IDLE with no stall.
- Grant and response never coincide: rvalid is only honoured while in RESP.
- Upstream holds its inputs while stall_out=1; inputs are ignored in REQ and RESP.
- Back-to-back: a new valid_in in the cycle the FSM returns to IDLE is accepted the following cycle. No overlap of transactions.
- Reset mid-transaction: immediate abort to IDLE with all outputs 0. The bus slave must tolerate the dropped request.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to REQ/RESP and increments each waiting cycle.
  - When it reaches TIMEOUT_CYC: bus_err_out pulses, wb_valid=1 with wb_reg_write=0, stall_out released, FSM returns to IDLE.
- MEM_TIMEOUT_EN undefined:
  - No counter; waits indefinitely.
  - bus_err_out tied 0.

Test Plan:
- ADD pass-through, addr_in=0x1234, rd=5, reg_write=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5; stall_out never high.
- LB at 0x1003, rdata=0x80AABBCC, gnt and rvalid each one cycle after request -> bus_addr=0x1000, wb_data=0xFFFFFF80; stall high for exactly 3 cycles.
- LHU at 0x2002, rdata=0x9ABC0000 -> wb_data=0x00009ABC. Same access as LH -> wb_data=0xFFFF9ABC.
- SB 0xDEADBEEF at 0x3001 with gnt delayed 4 cycles -> bus_req and fields stable for 4 cycles, wstrb=0010, wdata=0xEFEFEFEF, bus_we=1, wb_reg_write=0.
- LW at 0x4002 -> no bus_req, misalign_out pulse, wb_reg_write=0. Assert reset during RESP of a following LW -> all outputs 0 immediately, FSM in IDLE.
- With MEM_TIMEOUT_EN and TIMEOUT_CYC=8, rvalid never arrives -> bus_err_out pulses at the 8th waiting cycle, stall_out drops, and the next ADD passes through.
